mult_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that produces the HI/LO result pair for MULT, MULTU, DIV and DIVU in the multi-cycle CPU. The control unit issues a single-cycle `start` and then waits for `done`. HI/LO are held inside the block, replacing the separate Div/Mult-to-HI/LO muxes and HI/LO registers. Over the fixed 32-bit datapath this block adds width generality, an unsigned mode, abort on exception flush, and divide-by-zero reporting.

---
 rtl/mdu_pkg.sv | 8 +
 rtl/mult_div_unit.sv | 90 +++++++++
 tb/tb_mult_div_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes and FSM states shared by the multiply/divide unit and the control unit decode
package mdu_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle shift-add multiply / restoring divide producing HI/LO
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, nextState;
  logic opDiv, negRes, negRem, zeroDiv;
  logic [WIDTH-1:0] aMag, bMag;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic isDiv, isSigned, aNeg, bNeg, divByZero, accept;
  logic [WIDTH:0] mulSum, shifted, diff;
  logic [WIDTH-1:0] divRem, quo, rem;
  assign isDiv     = (op == OP_DIV) || (op == OP_DIVU);
  assign isSigned  = (op == OP_MULT) || (op == OP_DIV);
  assign aNeg      = isSigned & a[WIDTH-1];
  assign bNeg      = isSigned & b[WIDTH-1];
  assign divByZero = isDiv && (b == '0);
  // a start coinciding with done is dropped so the control unit sees a clean handshake
  assign accept    = start && !abort && !done && (state == S_IDLE);
  assign busy      = state != S_IDLE;
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? aMag : '0};
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff    = shifted - {1'b0, bMag};
  assign divRem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign prod    = negRes ? -acc : acc;
  assign quo     = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem     = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_comb begin
    nextState = state;
    if (abort) nextState = S_IDLE;
    else if (state == S_IDLE) nextState = accept ? (divByZero ? S_FINISH : S_RUN) : S_IDLE;
    else if (state == S_RUN) nextState = (cnt == CW'(1)) ? S_FINISH : S_RUN;
    else nextState = S_IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opDiv <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      zeroDiv <= 1'b0;
      aMag <= '0;
      bMag <= '0;
      cnt <= '0;
      acc <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opDiv <= isDiv;
        negRes <= aNeg ^ bNeg;
        negRem <= isDiv & aNeg;
        zeroDiv <= divByZero;
        aMag <= aNeg ? -a : a;
        bMag <= bNeg ? -b : b;
        cnt <= CW'(WIDTH);
        // lo half seeds the multiplier or the dividend; a raw dividend is parked in hi for divide-by-zero
        acc <= divByZero ? {a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, isDiv ? (aNeg ? -a : a) : (bNeg ? -b : b)};
      end else if (state == S_RUN) begin
        cnt <= cnt - CW'(1);
        acc <= opDiv ? {divRem, acc[WIDTH-2:0], ~diff[WIDTH]} : {mulSum, acc[WIDTH-1:1]};
      end else if (state == S_FINISH && !abort) begin
        done <= 1'b1;
        div_zero <= zeroDiv;
        hi <= zeroDiv ? acc[2*WIDTH-1:WIDTH] : opDiv ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= zeroDiv ? {WIDTH{1'b1}} : opDiv ? quo : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_mult_div_unit;
  import mdu_pkg::*;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic dz;
    int lat;
    longint t;
  } exp_t;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask
  always @(negedge clock) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("latency", 64'(($time - e.t) / 10 - 1), 64'(e.lat));
        chk("busy_in_done", 64'(busy), 64'(0));
      end
    end
  end
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ed, input int lat);
    exp_t e;
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    e.hi = eh; e.lo = el; e.dz = ed; e.lat = lat; e.t = $time;
    if (push) q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic waitDone();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      q.delete();
    end
  endtask
  initial begin
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33);
    waitDone();
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 33);
    waitDone();
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
    waitDone();
    issue(OP_DIVU, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0, 33);
    waitDone();
    issue(OP_DIV, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFFFFFF, 1, 1);
    waitDone();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0, 33);
    waitDone();
    issue(OP_MULT, 32'd5, 32'd6, 1, 32'd0, 32'd30, 0, 33);
    waitDone();
    issue(OP_DIVU, 32'd100, 32'd3, 0, '0, '0, 0, 0);
    repeat (8) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clock);
    chk("abort_lo_held", 64'(lo), 64'(30));
    chk("abort_hi_held", 64'(hi), 64'(0));
    chk("abort_dz_held", 64'(div_zero), 64'(0));
    issue(OP_MULTU, 32'd9, 32'd9, 1, 32'd0, 32'd81, 0, 33);
    repeat (4) @(negedge clock);
    op = OP_DIVU; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone();
    repeat (40) @(negedge clock);
    issue(OP_MULT, 32'd7, 32'd7, 0, '0, '0, 0, 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    issue(OP_MULT, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 33);
    waitDone();
    repeat (40) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
